// File: rtl/rx_huge_page_sched.sv
// Ping-pong scheduler for the two driver-supplied RX huge pages: hands out aligned
// per-frame slots from the page being filled and returns each page when it is full or idle.
module rx_huge_page_sched #(
  parameter int unsigned PAGE_LOG2  = 21,
  parameter int unsigned ALIGN_LOG2 = 7,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic                 trn_clk,
  input  logic                 reset_n,
  input  logic [63:0]          huge_page_addr_1,
  input  logic [63:0]          huge_page_addr_2,
  input  logic                 huge_page_status_1,
  input  logic                 huge_page_status_2,
  output logic                 huge_page_free_1,
  output logic                 huge_page_free_2,
  input  logic                 slot_req,
  input  logic [13:0]          slot_len,
  output logic                 slot_gnt,
  output logic [63:0]          slot_addr,
  output logic                 slot_page,
  input  logic                 wr_idle,
  output logic                 page_close,
  output logic [PAGE_LOG2:0]   page_used_bytes
);

  localparam int unsigned OW = PAGE_LOG2 + 1;
  localparam int unsigned SW = PAGE_LOG2 + 2;
  localparam logic [SW-1:0] PAGE_BYTES = SW'(1) << PAGE_LOG2;
  localparam logic [SW-1:0] ALIGN_MASK = (SW'(1) << ALIGN_LOG2) - SW'(1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_ACTIVE,
    ST_DRAIN,
    ST_RELEASE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cur, w_cur_nxt;
  logic [63:0]     r_base, w_base_nxt;
  logic [OW-1:0]   r_offset, w_offset_nxt;
  logic [15:0]     r_idle, w_idle_nxt;

  logic            r_free_1, w_free_1_nxt;
  logic            r_free_2, w_free_2_nxt;
  logic            r_slot_gnt, w_slot_gnt_nxt;
  logic [63:0]     r_slot_addr, w_slot_addr_nxt;
  logic            r_slot_page, w_slot_page_nxt;
  logic            r_page_close, w_page_close_nxt;
  logic [OW-1:0]   r_used, w_used_nxt;

  logic [SW-1:0]   w_len_ext;
  logic [SW-1:0]   w_rlen;
  logic [SW-1:0]   w_end;
  logic            w_fits;
  logic            w_status_cur;
  logic [63:0]     w_addr_cur;
  logic [16:0]     w_idle_inc;

  // Slot size: length rounded up to the alignment, zero-length frames still take one unit
  assign w_len_ext    = SW'(slot_len);
  assign w_rlen       = (slot_len == 14'd0) ? (ALIGN_MASK + SW'(1))
                                            : ((w_len_ext + ALIGN_MASK) & ~ALIGN_MASK);
  assign w_end        = SW'(r_offset) + w_rlen;
  assign w_fits       = (w_end <= PAGE_BYTES);
  assign w_status_cur = r_cur ? huge_page_status_2 : huge_page_status_1;
  assign w_addr_cur   = r_cur ? huge_page_addr_2 : huge_page_addr_1;
  assign w_idle_inc   = {1'b0, r_idle} + 17'd1;

  assign huge_page_free_1 = r_free_1;
  assign huge_page_free_2 = r_free_2;
  assign slot_gnt         = r_slot_gnt;
  assign slot_addr        = r_slot_addr;
  assign slot_page        = r_slot_page;
  assign page_close       = r_page_close;
  assign page_used_bytes  = r_used;

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_WAIT;
      r_cur        <= 1'b0;
      r_base       <= '0;
      r_offset     <= '0;
      r_idle       <= '0;
      r_free_1     <= 1'b0;
      r_free_2     <= 1'b0;
      r_slot_gnt   <= 1'b0;
      r_slot_addr  <= '0;
      r_slot_page  <= 1'b0;
      r_page_close <= 1'b0;
      r_used       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur        <= w_cur_nxt;
      r_base       <= w_base_nxt;
      r_offset     <= w_offset_nxt;
      r_idle       <= w_idle_nxt;
      r_free_1     <= w_free_1_nxt;
      r_free_2     <= w_free_2_nxt;
      r_slot_gnt   <= w_slot_gnt_nxt;
      r_slot_addr  <= w_slot_addr_nxt;
      r_slot_page  <= w_slot_page_nxt;
      r_page_close <= w_page_close_nxt;
      r_used       <= w_used_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cur_nxt        = r_cur;
    w_base_nxt       = r_base;
    w_offset_nxt     = r_offset;
    w_idle_nxt       = r_idle;
    w_free_1_nxt     = 1'b0;
    w_free_2_nxt     = 1'b0;
    w_slot_gnt_nxt   = 1'b0;
    w_slot_addr_nxt  = '0;
    w_slot_page_nxt  = 1'b0;
    w_page_close_nxt = 1'b0;
    w_used_nxt       = '0;

    case (r_state)
      ST_WAIT: begin
        if (w_status_cur) begin
          w_base_nxt   = w_addr_cur;
          w_offset_nxt = '0;
          w_idle_nxt   = '0;
          w_state_nxt  = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        // A request already answered by the grant on the wire is not re-evaluated
        if (slot_req && !r_slot_gnt) begin
          w_idle_nxt = '0;
          if (w_fits) begin
            w_slot_gnt_nxt  = 1'b1;
            w_slot_addr_nxt = r_base + 64'(r_offset);
            w_slot_page_nxt = r_cur;
            w_offset_nxt    = OW'(w_end);
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else if (slot_req) begin
          w_idle_nxt = '0;
        end else if (r_offset != '0) begin
          w_idle_nxt = w_idle_inc[15:0];
          if (w_idle_inc >= {1'b0, TIMEOUT}) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (wr_idle) begin
          w_free_1_nxt     = ~r_cur;
          w_free_2_nxt     = r_cur;
          w_page_close_nxt = 1'b1;
          w_used_nxt       = r_offset;
          w_state_nxt      = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        w_cur_nxt   = ~r_cur;
        w_state_nxt = ST_WAIT;
      end

      default: w_state_nxt = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_rx_huge_page_sched.sv
// Directed bench for rx_huge_page_sched with a cycle-level reference model of the
// page-sharing rules and literal expectations on addresses, used bytes and latencies.
module tb_rx_huge_page_sched;

  localparam int unsigned P     = 15;
  localparam int unsigned A     = 7;
  localparam logic [15:0] TO    = 16'd100;
  localparam longint      PAGE  = longint'(1) << P;
  localparam longint      ALIGN = longint'(1) << A;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] huge_page_addr_1, huge_page_addr_2;
  logic        huge_page_status_1, huge_page_status_2;
  logic        huge_page_free_1, huge_page_free_2;
  logic        slot_req;
  logic [13:0] slot_len;
  logic        slot_gnt;
  logic [63:0] slot_addr;
  logic        slot_page;
  logic        wr_idle;
  logic        page_close;
  logic [P:0]  page_used_bytes;

  rx_huge_page_sched #(
    .PAGE_LOG2  (P),
    .ALIGN_LOG2 (A),
    .TIMEOUT    (TO)
  ) dut (
    .trn_clk            (trn_clk),
    .reset_n            (reset_n),
    .huge_page_addr_1   (huge_page_addr_1),
    .huge_page_addr_2   (huge_page_addr_2),
    .huge_page_status_1 (huge_page_status_1),
    .huge_page_status_2 (huge_page_status_2),
    .huge_page_free_1   (huge_page_free_1),
    .huge_page_free_2   (huge_page_free_2),
    .slot_req           (slot_req),
    .slot_len           (slot_len),
    .slot_gnt           (slot_gnt),
    .slot_addr          (slot_addr),
    .slot_page          (slot_page),
    .wr_idle            (wr_idle),
    .page_close         (page_close),
    .page_used_bytes    (page_used_bytes)
  );

  always #5 trn_clk = ~trn_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: page owner, fill level and idle age, advanced once per clock
  bit          m_open, m_drain, m_rel, m_cur;
  logic [63:0] m_base;
  longint      m_off;
  int          m_idle;
  logic        e_gnt, e_page, e_free1, e_free2, e_close;
  logic [63:0] e_addr;
  logic [P:0]  e_used;

  initial begin
    m_open = 0; m_drain = 0; m_rel = 0; m_cur = 0; m_base = '0; m_off = 0; m_idle = 0;
    e_gnt = 0; e_page = 0; e_free1 = 0; e_free2 = 0; e_close = 0; e_addr = '0; e_used = '0;
  end

  function automatic longint slot_bytes(input int len);
    if (len == 0) return ALIGN;
    return ((longint'(len) + ALIGN - 1) / ALIGN) * ALIGN;
  endfunction

  task automatic model_step();
    bit     prev_gnt;
    longint need;
    if (!reset_n) begin
      m_open = 0; m_drain = 0; m_rel = 0; m_cur = 0; m_base = '0; m_off = 0; m_idle = 0;
      e_gnt = 0; e_page = 0; e_free1 = 0; e_free2 = 0; e_close = 0; e_addr = '0; e_used = '0;
      return;
    end
    prev_gnt = e_gnt;
    e_gnt = 0; e_page = 0; e_addr = '0; e_free1 = 0; e_free2 = 0; e_close = 0; e_used = '0;
    if (m_rel) begin
      m_rel = 0;
      m_cur = ~m_cur;
    end else if (m_drain) begin
      if (wr_idle) begin
        m_drain = 0;
        m_rel   = 1;
        e_close = 1;
        e_used  = (P+1)'(m_off);
        if (m_cur) e_free2 = 1; else e_free1 = 1;
      end
    end else if (!m_open) begin
      if (m_cur ? huge_page_status_2 : huge_page_status_1) begin
        m_open = 1;
        m_base = m_cur ? huge_page_addr_2 : huge_page_addr_1;
        m_off  = 0;
        m_idle = 0;
      end
    end else if (slot_req && !prev_gnt) begin
      m_idle = 0;
      need   = slot_bytes(int'(slot_len));
      if (m_off + need <= PAGE) begin
        e_gnt  = 1;
        e_page = m_cur;
        e_addr = m_base + 64'(m_off);
        m_off  = m_off + need;
      end else begin
        m_open  = 0;
        m_drain = 1;
      end
    end else if (slot_req) begin
      m_idle = 0;
    end else if (m_off > 0) begin
      m_idle++;
      if (m_idle >= int'(TO)) begin
        m_open  = 0;
        m_drain = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge trn_clk or negedge reset_n);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge
  initial forever begin
    @(negedge trn_clk);
    chk("grant_path", {slot_gnt, slot_page, slot_addr}, {e_gnt, e_page, e_addr});
    chk("close_path", {huge_page_free_1, huge_page_free_2, page_close, page_used_bytes},
                      {e_free1, e_free2, e_close, e_used});
  end

  // Writer/driver side: one cycle step, dropping the request as soon as it is granted
  int          cyc_no = 0, ngnt = 0, nclose = 0, nfree1 = 0, nfree2 = 0, g_cyc = 0, c_cyc = 0;
  logic [63:0] g_addr = '0;
  logic        g_page = 1'b0;
  logic [P:0]  c_used = '0;

  task automatic cyc();
    @(posedge trn_clk);
    #1;
    cyc_no++;
    if (slot_gnt) begin
      slot_req = 1'b0;
      g_addr   = slot_addr;
      g_page   = slot_page;
      g_cyc    = cyc_no;
      ngnt++;
    end
    if (page_close) begin
      c_used = page_used_bytes;
      c_cyc  = cyc_no;
      nclose++;
    end
    if (huge_page_free_1) nfree1++;
    if (huge_page_free_2) nfree2++;
  endtask

  task automatic wait_gnt(input string name, input int budget);
    int n0;
    bit ok;
    n0 = ngnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (ngnt != n0) begin ok = 1; break; end
    end
    chk({name, "_granted"}, ok, 1);
  endtask

  task automatic wait_close(input string name, input int budget);
    int n0;
    bit ok;
    n0 = nclose;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (nclose != n0) begin ok = 1; break; end
    end
    chk({name, "_closed"}, ok, 1);
  endtask

  task automatic grant(input int len, input logic [63:0] addr, input logic page, input string name);
    slot_len = 14'(len);
    slot_req = 1'b1;
    wait_gnt(name, 20);
    chk({name, "_addr"}, g_addr, addr);
    chk({name, "_page"}, g_page, page);
  endtask

  initial begin
    int n0, nc0, k;
    huge_page_addr_1 = '0; huge_page_addr_2 = '0;
    huge_page_status_1 = 1'b0; huge_page_status_2 = 1'b0;
    slot_req = 1'b0; slot_len = '0; wr_idle = 1'b1;

    repeat (3) cyc();
    chk("reset_outputs", {slot_gnt, slot_addr, slot_page, huge_page_free_1, huge_page_free_2,
                          page_close, page_used_bytes}, '0);
    reset_n = 1'b1;

    // Basic fill of page 1: 60->128, 200->256, 128->128 bytes
    huge_page_addr_1   = 64'h1_0000_0000;
    huge_page_status_1 = 1'b1;
    grant(60,  64'h1_0000_0000, 1'b0, "basic0");
    grant(200, 64'h1_0000_0080, 1'b0, "basic1");
    grant(128, 64'h1_0000_0180, 1'b0, "basic2");
    grant(16383, 64'h1_0000_0200, 1'b0, "fill1");
    grant(15744, 64'h1_0000_4200, 1'b0, "fill2");

    // Page full at 0x7F80: 256 bytes do not fit, writer busy holds the drain
    wr_idle = 1'b0;
    n0 = ngnt; nc0 = nclose;
    slot_len = 14'd256;
    slot_req = 1'b1;
    repeat (10) cyc();
    chk("full_no_grant", ngnt - n0, 0);
    chk("full_no_close", nclose - nc0, 0);
    wr_idle = 1'b1;
    wait_close("full", 5);
    chk("full_used", c_used, 16'h7F80);
    chk("full_free1", nfree1, 1);
    chk("full_free2", nfree2, 0);
    huge_page_status_1 = 1'b0;
    huge_page_addr_2   = 64'h2_0000_0000;
    huge_page_status_2 = 1'b1;
    wait_gnt("carry", 20);
    chk("carry_addr", g_addr, 64'h2_0000_0000);
    chk("carry_page", g_page, 1'b1);
    // Close pulse (RELEASE), then WAIT, then ACTIVE before the grant
    chk("free_to_grant", g_cyc - c_cyc, 3);

    // Exact fit: page 2 reaches 0x8000, then a 1-byte request closes it
    grant(16383, 64'h2_0000_0100, 1'b1, "exact0");
    grant(15872, 64'h2_0000_4100, 1'b1, "exact1");
    grant(256,   64'h2_0000_7F00, 1'b1, "exact2");
    slot_len = 14'd1;
    slot_req = 1'b1;
    wait_close("exact", 10);
    chk("exact_used", c_used, 16'h8000);
    chk("exact_free2", nfree2, 1);

    // Page 2 still offered, but page 1 is next in turn
    n0 = ngnt;
    repeat (10) cyc();
    chk("no_skip", ngnt - n0, 0);
    huge_page_status_2 = 1'b0;
    huge_page_addr_1   = 64'h3_0000_0000;
    huge_page_status_1 = 1'b1;
    wait_gnt("turn", 20);
    chk("turn_addr", g_addr, 64'h3_0000_0000);
    chk("turn_page", g_page, 1'b0);

    // Idle timeout: first idle edge follows the grant, 100th drains, next edge releases
    wait_close("timeout", 150);
    chk("timeout_latency", c_cyc - g_cyc, 101);
    chk("timeout_used", c_used, 16'h0080);
    chk("timeout_free1", nfree1, 2);

    // Empty page is never timed out
    huge_page_status_1 = 1'b0;
    huge_page_addr_2   = 64'h5_0000_0000;
    huge_page_status_2 = 1'b1;
    nc0 = nclose;
    repeat (300) cyc();
    chk("empty_no_close", nclose - nc0, 0);

    // Drain hold: writer busy for 40 cycles after the page fills
    grant(16383, 64'h5_0000_0000, 1'b1, "hold0");
    grant(16383, 64'h5_0000_4000, 1'b1, "hold1");
    wr_idle = 1'b0;
    n0 = ngnt; nc0 = nclose;
    slot_len = 14'd1;
    slot_req = 1'b1;
    repeat (40) cyc();
    chk("hold_no_grant", ngnt - n0, 0);
    chk("hold_no_close", nclose - nc0, 0);
    wr_idle = 1'b1;
    k = cyc_no;
    wait_close("hold", 5);
    chk("hold_release_latency", c_cyc - k, 1);
    chk("hold_used", c_used, 16'h8000);
    chk("hold_free2", nfree2, 2);
    huge_page_status_2 = 1'b0;
    huge_page_addr_1   = 64'h6_0000_0000;
    huge_page_status_1 = 1'b1;
    wait_gnt("after_hold", 20);
    chk("after_hold_addr", g_addr, 64'h6_0000_0000);

    // Reset while a grant is on the wire: outputs clear without waiting for a clock
    slot_len = 14'd10;
    slot_req = 1'b1;
    wait_gnt("pre_reset", 20);
    chk("pre_reset_addr", g_addr, 64'h6_0000_0080);
    reset_n = 1'b0;
    #1;
    chk("reset_async", {slot_gnt, slot_addr, slot_page, huge_page_free_1, huge_page_free_2,
                        page_close, page_used_bytes}, '0);
    huge_page_status_1 = 1'b0;
    huge_page_addr_2   = 64'h7_0000_0000;
    huge_page_status_2 = 1'b1;
    @(negedge trn_clk);
    #1 reset_n = 1'b1;
    n0 = ngnt;
    slot_len = 14'd10;
    slot_req = 1'b1;
    repeat (10) cyc();
    chk("reset_waits_page1", ngnt - n0, 0);
    huge_page_addr_1   = 64'h8_0000_0000;
    huge_page_status_1 = 1'b1;
    wait_gnt("post_reset", 20);
    chk("post_reset_addr", g_addr, 64'h8_0000_0000);
    chk("post_reset_page", g_page, 1'b0);

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
